// File: rtl/full_adder_using_half_adder_if.sv
// rtl/full_adder_using_half_adder_if.sv - operand/result bundle for the registered ripple adder
//
// Purpose: groups the adder operands and registered results so that
//          producers and the adder share one typed connection.
// Ports (signals):
//   a      WIDTH  operand A, unsigned (master -> slave)
//   b      WIDTH  operand B, unsigned (master -> slave)
//   cin    1      carry into bit 0    (master -> slave)
//   sum    WIDTH  registered sum      (slave -> master)
//   carry  1      registered carry out of bit WIDTH-1 (slave -> master)
// Modports: master drives operands, slave (the adder) drives results.

interface full_adder_using_half_adder_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             carry;

   modport master (
      output a,
      output b,
      output cin,
      input  sum,
      input  carry
   );

   modport slave (
      input  a,
      input  b,
      input  cin,
      output sum,
      output carry
   );
endinterface

// File: rtl/full_adder_using_half_adder.sv
// rtl/full_adder_using_half_adder.sv - registered ripple-carry adder built from half-adder cells
//
// Purpose: computes {carry, sum} = a + b + cin at WIDTH+1 bits and registers
//          the result with exactly one cycle of latency. Each bit is two
//          half-adder cells plus an OR for the carry; bits ripple from bit 0.
//          WIDTH=1 is the single-bit full adder. Legal WIDTH is 1..32.
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset; clears sum and carry
//   bus    slave    a, b, cin in; sum, carry out (registered)

module full_adder_using_half_adder #(
   parameter int WIDTH = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   full_adder_using_half_adder_if.slave  bus
);

   // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_comb;

   assign c[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic s1;
      logic c1;
      logic c2;

      // First half adder: the two operand bits.
      assign s1 = bus.a[i] ^ bus.b[i];
      assign c1 = bus.a[i] & bus.b[i];

      // Second half adder: partial sum with the incoming ripple carry.
      assign sum_comb[i] = s1 ^ c[i];
      assign c2          = s1 & c[i];

      // The two half-adder carries can never both be 1, so OR suffices.
      assign c[i+1] = c1 | c2;
   end

   // Reset wins over the add, so an in-flight result is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.sum   <= '0;
         bus.carry <= 1'b0;
      end else begin
         bus.sum   <= sum_comb;
         bus.carry <= c[WIDTH];
      end
   end

endmodule

// File: tb/tb_full_adder_using_half_adder.sv
// tb/tb_full_adder_using_half_adder.sv - directed and random checks of the registered adder at WIDTH 1 and 8

module tb_full_adder_using_half_adder;

   logic clk;
   logic rst_n;

   int n_compared;
   int n_mismatched;

   full_adder_using_half_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_using_half_adder_if #(.WIDTH(8)) bus8 ();

   full_adder_using_half_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   full_adder_using_half_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic a, input logic b, input logic cin);
      bus1.a   = a;
      bus1.b   = b;
      bus1.cin = cin;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      bus8.a   = a;
      bus8.b   = b;
      bus8.cin = cin;
   endtask

   initial begin
      logic [7:0] sum_tab;
      logic [7:0] carry_tab;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] rexp;

      n_compared   = 0;
      n_mismatched = 0;
      // Bit v of each table is the expected result for {a,b,cin} = v.
      sum_tab   = 8'b1001_0110;
      carry_tab = 8'b1110_1000;

      // Reset held for two edges with non-zero inputs, which must be ignored.
      rst_n = 1'b0;
      drive1(1'b1, 1'b1, 1'b1);
      drive8(8'hFF, 8'hFF, 1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rst_sum1",   64'(bus1.sum),   64'd0);
         check("rst_carry1", 64'(bus1.carry), 64'd0);
         check("rst_sum8",   64'(bus8.sum),   64'd0);
         check("rst_carry8", 64'(bus8.carry), 64'd0);
      end
      rst_n = 1'b1;

      // Exhaustive single-bit sweep, result one edge after each vector.
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         drive1(vv[2], vv[1], vv[0]);
         tick();
         check($sformatf("sweep_sum_%0d", v),   64'(bus1.sum),   64'(sum_tab[v]));
         check($sformatf("sweep_carry_%0d", v), 64'(bus1.carry), 64'(carry_tab[v]));
      end

      // No combinational path: changing inputs between edges leaves outputs alone.
      drive1(1'b0, 1'b0, 1'b0);
      #2;
      check("hold_sum1",   64'(bus1.sum),   64'd1);
      check("hold_carry1", 64'(bus1.carry), 64'd1);

      // WIDTH=8 ripple through every bit.
      drive8(8'hFF, 8'h00, 1'b1);
      tick();
      check("ripple_sum8",   64'(bus8.sum),   64'h00);
      check("ripple_carry8", 64'(bus8.carry), 64'd1);

      drive8(8'hFF, 8'hFF, 1'b1);
      tick();
      check("ones_sum8",   64'(bus8.sum),   64'hFF);
      check("ones_carry8", 64'(bus8.carry), 64'd1);

      drive8(8'h00, 8'h00, 1'b0);
      tick();
      check("zeros_sum8",   64'(bus8.sum),   64'h00);
      check("zeros_carry8", 64'(bus8.carry), 64'd0);

      drive8(8'h5A, 8'h3C, 1'b0);
      tick();
      check("mixed_sum8",   64'(bus8.sum),   64'h96);
      check("mixed_carry8", 64'(bus8.carry), 64'd0);

      // Mid-stream reset pulse on a 1+1+1 stream.
      drive1(1'b1, 1'b1, 1'b1);
      tick();
      check("pre_pulse_sum1",   64'(bus1.sum),   64'd1);
      check("pre_pulse_carry1", 64'(bus1.carry), 64'd1);
      rst_n = 1'b0;
      tick();
      check("pulse_sum1",   64'(bus1.sum),   64'd0);
      check("pulse_carry1", 64'(bus1.carry), 64'd0);
      rst_n = 1'b1;
      tick();
      check("post_pulse_sum1",   64'(bus1.sum),   64'd1);
      check("post_pulse_carry1", 64'(bus1.carry), 64'd1);

      // Random WIDTH=8 vectors against an integer reference.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         rexp = 9'(ra) + 9'(rb) + 9'(rc);
         drive8(ra, rb, rc);
         tick();
         check($sformatf("rand_%0d_%0h_%0h_%0h", n, ra, rb, rc),
               64'({bus8.carry, bus8.sum}), 64'(rexp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
